regfile_preloader: RTL and testbench
====================================

Name: regfile_preloader

Overview:
- Hardware counterpart to the bench's register-dump harness. The harness reads the regfile after a run; this block writes it before a run.
- Holds the processor in reset and streams caller-supplied values into r1..r(NUM_REGS-1) through the regfile write port.
- Then releases the processor and hands the write port back to it.
- Sits between processor write-port outputs (rwe/rd/rData) and my_regfile write inputs; used for FPGA bring-up and bench preloading.

Parameters:
- NUM_REGS, 32, architectural register count; r0 is never written.
- DATA_W, 32, register data width.
- HOLD_CYCLES, 2, cycles processor reset stays asserted after the last load word is accepted; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: begin a load session.
- skip  in  1  single-cycle pulse: release the processor without loading.
- in_valid  in  1  load word valid.
- in_ready  out  1  block can accept a load word.
- in_data  in  DATA_W  load word; words arrive in order r1, r2, ... r(NUM_REGS-1).
- cpu_rwe  in  1  processor regfile write enable.
- cpu_rd  in  5  processor write register index.
- cpu_rData  in  DATA_W  processor write data.
- rf_we  out  1  regfile write enable.
- rf_wreg  out  5  regfile write register index.
- rf_wdata  out  DATA_W  regfile write data.
- cpu_reset  out  1  active-high reset to the processor.
- busy  out  1  high in LOAD or HOLD.
- done  out  1  one-cycle pulse on entry to RUN.

Behaviour:
- Reset values (reset low): state=IDLE, cpu_reset=1, in_ready=0, rf_we=0, rf_wreg=0, rf_wdata=0, busy=0, done=0, idx=1, hold_cnt=0.
- FSM states: IDLE, LOAD, HOLD, RUN.
- IDLE: cpu_reset=1. start -> LOAD with idx=1. skip -> HOLD with hold_cnt=0. If start and skip are both high, start wins.
- LOAD: in_ready=1, cpu_reset=1.
  - Handshake on in_valid && in_ready.
  - Next cycle: registered write pulse rf_we=1, rf_wreg=idx, rf_wdata=captured in_data; idx increments.
  - One write per accepted word; in_valid gaps are allowed and insert no write.
  - On accepting the word for idx=NUM_REGS-1 -> HOLD; in_ready drops the following cycle.
  - start and skip are ignored in LOAD.
- HOLD: cpu_reset=1, in_ready=0. The final load write lands in the first HOLD cycle. hold_cnt counts HOLD_CYCLES cycles, then -> RUN; done=1 for that single cycle.
- RUN:
  - cpu_reset=0.
  - Write port is a pure combinational pass-through: rf_we=cpu_rwe, rf_wreg=cpu_rd, rf_wdata=cpu_rData.
  - start -> LOAD: cpu_reset reasserts on the next edge and idx=1. Any processor write in that same cycle still passes through.
  - skip is ignored in RUN.
- Outside RUN: processor write inputs are fully masked; rf_we is driven only by the load pulse.
- Register index width: 5 bits; idx never reaches NUM_REGS.
- Reset asserted mid-session: immediate return to IDLE, cpu_reset=1, partially loaded registers keep their values. The regfile's own reset is not driven by this block.
- busy = (state==LOAD) || (state==HOLD).

Decomposition:
- Shared package: state encoding (IDLE/LOAD/HOLD/RUN, 2 bits), REG_IDX_W=5, NUM_REGS default.
- One sub-module is natural: preload_write_mux, the combinational select between the load write pulse and the processor write port, keyed on in_run.

Test Plan:
- Reset low then high, no start -> cpu_reset=1, rf_we=0, in_ready=0 indefinitely; cpu_rwe=1 with cpu_rd=5 produces no write.
- start, stream values 100+i for r1..r31 back-to-back -> 31 rf_we pulses with rf_wreg=1..31 and rf_wdata=101..131. After the last accept: 2 HOLD cycles, then done=1 for one cycle and cpu_reset=0. Bench register dump reads r1=101 ... r31=131, r0=0.
- Same stream with in_valid low every other cycle -> identical writes with gaps, no duplicates, same final regfile contents.
- In RUN, cpu_rwe=1, cpu_rd=7, cpu_rData=42 -> rf_we=1, rf_wreg=7, rf_wdata=42 in the same cycle.
- Reset low after 10 words accepted -> next edge state IDLE, cpu_reset=1, r1..r10 keep loaded values. A new start reloads from r1.
- skip in IDLE -> no writes, done pulses after HOLD_CYCLES, cpu_reset=0. start and skip together -> LOAD entered.

Source files
------------

// File: rtl/regfile_preloader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_preloader_pkg : shared state encoding and index width for the preloader
// Revision: 1.0
// ----------------------------------------------------------------------------
package regfile_preloader_pkg;

    localparam int REG_IDX_W        = 5;
    localparam int NUM_REGS_DEFAULT = 32;
    localparam int HOLD_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

endpackage : regfile_preloader_pkg
`default_nettype wire

// File: rtl/regfile_preloader_write_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_preloader_write_mux : selects preload write pulse or processor write port
// Revision: 1.0
// ----------------------------------------------------------------------------
module regfile_preloader_write_mux
    import regfile_preloader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 in_run_i,
    input  logic                 ld_we_i,
    input  logic [REG_IDX_W-1:0] ld_wreg_i,
    input  logic [DATA_W-1:0]    ld_wdata_i,
    input  logic                 cpu_rwe_i,
    input  logic [REG_IDX_W-1:0] cpu_rd_i,
    input  logic [DATA_W-1:0]    cpu_rData_i,
    output logic                 rf_we_o,
    output logic [REG_IDX_W-1:0] rf_wreg_o,
    output logic [DATA_W-1:0]    rf_wdata_o
);

    // The processor port is fully masked whenever the preloader owns the regfile.
    always_comb begin
        rf_we_o    = ld_we_i;
        rf_wreg_o  = ld_wreg_i;
        rf_wdata_o = ld_wdata_i;
        if (in_run_i) begin
            rf_we_o    = cpu_rwe_i;
            rf_wreg_o  = cpu_rd_i;
            rf_wdata_o = cpu_rData_i;
        end
    end

endmodule : regfile_preloader_write_mux
`default_nettype wire

// File: rtl/regfile_preloader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_preloader : holds the CPU in reset, streams r1..r(NUM_REGS-1), then releases it
// Revision: 1.0
// ----------------------------------------------------------------------------
module regfile_preloader
    import regfile_preloader_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEFAULT,
    parameter int DATA_W      = 32,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 skip,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 cpu_rwe,
    input  logic [REG_IDX_W-1:0] cpu_rd,
    input  logic [DATA_W-1:0]    cpu_rData,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_wreg,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done
);

    localparam logic [REG_IDX_W-1:0]  LAST_IDX  = REG_IDX_W'(NUM_REGS - 1);
    localparam logic [REG_IDX_W-1:0]  FIRST_IDX = REG_IDX_W'(1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);

    state_e                 state_q;
    logic [REG_IDX_W-1:0]   idx_q;
    logic [HOLD_CNT_W-1:0]  hold_cnt_q;
    logic                   in_ready_q;
    logic                   cpu_reset_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ld_we_q;
    logic [REG_IDX_W-1:0]   ld_wreg_q;
    logic [DATA_W-1:0]      ld_wdata_q;
    logic                   load_accept;

    assign load_accept = (state_q == ST_LOAD) && in_valid && in_ready_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= FIRST_IDX;
            hold_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ld_we_q     <= 1'b0;
            ld_wreg_q   <= '0;
            ld_wdata_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            ld_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cpu_reset_q <= 1'b1;
                    if (start) begin
                        state_q    <= ST_LOAD;
                        idx_q      <= FIRST_IDX;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (skip) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_accept) begin
                        ld_we_q    <= 1'b1;
                        ld_wreg_q  <= idx_q;
                        ld_wdata_q <= in_data;
                        // The last index is held rather than wrapped so idx never reaches NUM_REGS.
                        if (idx_q == LAST_IDX) begin
                            state_q    <= ST_HOLD;
                            hold_cnt_q <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + FIRST_IDX;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= ST_RUN;
                        cpu_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        state_q     <= ST_LOAD;
                        idx_q       <= FIRST_IDX;
                        in_ready_q  <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cpu_reset_q <= 1'b1;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    regfile_preloader_write_mux #(
        .DATA_W (DATA_W)
    ) u_write_mux (
        .in_run_i    (state_q == ST_RUN),
        .ld_we_i     (ld_we_q),
        .ld_wreg_i   (ld_wreg_q),
        .ld_wdata_i  (ld_wdata_q),
        .cpu_rwe_i   (cpu_rwe),
        .cpu_rd_i    (cpu_rd),
        .cpu_rData_i (cpu_rData),
        .rf_we_o     (rf_we),
        .rf_wreg_o   (rf_wreg),
        .rf_wdata_o  (rf_wdata)
    );

    assign in_ready  = in_ready_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : regfile_preloader
`default_nettype wire

// File: tb/tb_regfile_preloader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_preloader : directed bench with a behavioural regfile and write log
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_regfile_preloader;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              skip = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              cpu_rwe = 1'b0;
    logic [4:0]        cpu_rd = '0;
    logic [DATA_W-1:0] cpu_rData = '0;
    logic              rf_we;
    logic [4:0]        rf_wreg;
    logic [DATA_W-1:0] rf_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] rf_model [NUM_REGS];
    logic [4:0]        log_reg [$];
    logic [DATA_W-1:0] log_data [$];

    always #5 clock = ~clock;

    regfile_preloader #(
        .NUM_REGS    (NUM_REGS),
        .DATA_W      (DATA_W),
        .HOLD_CYCLES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .skip      (skip),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cpu_rwe   (cpu_rwe),
        .cpu_rd    (cpu_rd),
        .cpu_rData (cpu_rData),
        .rf_we     (rf_we),
        .rf_wreg   (rf_wreg),
        .rf_wdata  (rf_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done)
    );

    // Stand-in for my_regfile: captures every write, r0 hard-wired to zero.
    always @(negedge clock) begin
        if (rf_we) begin
            log_reg.push_back(rf_wreg);
            log_data.push_back(rf_wdata);
            if (rf_wreg != 5'd0) rf_model[rf_wreg] = rf_wdata;
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < NUM_REGS; r++) rf_model[r] = '0;
        log_reg.delete();
        log_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Streams words 100+i for r1..r(nwords); optional idle cycle before each word.
    task automatic load_words(input int nwords, input bit gaps);
        for (int i = 1; i <= nwords; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = '0;
                step();
            end
            in_valid = 1'b1;
            in_data  = DATA_W'(100 + i);
            for (int t = 0; t < 8 && !in_ready; t++) step();
            if (!in_ready) check_vec("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_log_full(input string tag);
        check_vec({tag, "_count"}, 64'(log_reg.size()), 64'd31);
        for (int i = 0; i < log_reg.size() && i < 31; i++) begin
            check_vec({tag, "_wreg"}, 64'(log_reg[i]), 64'(i + 1));
            check_vec({tag, "_wdata"}, 64'(log_data[i]), 64'(101 + i));
        end
    endtask

    // Expected dump: r1..r(upto) hold 100+r, everything else still zero.
    task automatic check_dump(input string tag, input int upto);
        for (int r = 0; r < NUM_REGS; r++)
            check_vec(tag, 64'(rf_model[r]), (r >= 1 && r <= upto) ? 64'(100 + r) : 64'd0);
    endtask

    initial begin
        clear_model();

        // Reset state
        step();
        check_vec("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check_vec("rst_in_ready", 64'(in_ready), 64'd0);
        check_vec("rst_rf_we", 64'(rf_we), 64'd0);
        check_vec("rst_rf_wreg", 64'(rf_wreg), 64'd0);
        check_vec("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        check_vec("rst_busy", 64'(busy), 64'd0);
        check_vec("rst_done", 64'(done), 64'd0);
        reset = 1'b1;

        // Idle: processor writes must be masked
        cpu_rwe = 1'b1; cpu_rd = 5'd5; cpu_rData = 32'd55;
        for (int c = 0; c < 5; c++) begin
            step();
            check_vec("idle_rf_we", 64'(rf_we), 64'd0);
            check_vec("idle_cpu_reset", 64'(cpu_reset), 64'd1);
            check_vec("idle_in_ready", 64'(in_ready), 64'd0);
        end
        cpu_rwe = 1'b0;
        check_vec("idle_writes", 64'(log_reg.size()), 64'd0);

        // Back-to-back full load
        pulse_start();
        check_vec("load_in_ready", 64'(in_ready), 64'd1);
        check_vec("load_busy", 64'(busy), 64'd1);
        load_words(31, 1'b0);
        check_vec("hold1_in_ready", 64'(in_ready), 64'd0);
        check_vec("hold1_rf_we", 64'(rf_we), 64'd1);
        check_vec("hold1_rf_wreg", 64'(rf_wreg), 64'd31);
        check_vec("hold1_cpu_reset", 64'(cpu_reset), 64'd1);
        check_vec("hold1_done", 64'(done), 64'd0);
        step();
        check_vec("hold2_rf_we", 64'(rf_we), 64'd0);
        check_vec("hold2_done", 64'(done), 64'd0);
        check_vec("hold2_busy", 64'(busy), 64'd1);
        step();
        check_vec("run_done", 64'(done), 64'd1);
        check_vec("run_cpu_reset", 64'(cpu_reset), 64'd0);
        check_vec("run_busy", 64'(busy), 64'd0);
        step();
        check_vec("run_done_drop", 64'(done), 64'd0);
        check_log_full("b2b");
        check_dump("b2b_dump", 31);

        // RUN pass-through, then skip is ignored
        cpu_rwe = 1'b1; cpu_rd = 5'd7; cpu_rData = 32'd42;
        #1;
        check_vec("pass_rf_we", 64'(rf_we), 64'd1);
        check_vec("pass_rf_wreg", 64'(rf_wreg), 64'd7);
        check_vec("pass_rf_wdata", 64'(rf_wdata), 64'd42);
        step();
        cpu_rwe = 1'b0;
        skip = 1'b1;
        step();
        skip = 1'b0;
        check_vec("run_skip_cpu_reset", 64'(cpu_reset), 64'd0);
        check_vec("run_skip_busy", 64'(busy), 64'd0);

        // start in RUN with a same-cycle processor write
        cpu_rwe = 1'b1; cpu_rd = 5'd9; cpu_rData = 32'd77;
        start = 1'b1;
        #1;
        check_vec("restart_pass_we", 64'(rf_we), 64'd1);
        check_vec("restart_pass_wreg", 64'(rf_wreg), 64'd9);
        step();
        start = 1'b0;
        check_vec("restart_cpu_reset", 64'(cpu_reset), 64'd1);
        check_vec("restart_in_ready", 64'(in_ready), 64'd1);
        check_vec("restart_masked_we", 64'(rf_we), 64'd0);
        cpu_rwe = 1'b0;
        clear_model();

        // Gapped stream
        load_words(31, 1'b1);
        for (int c = 0; c < 4; c++) step();
        check_vec("gap_cpu_reset", 64'(cpu_reset), 64'd0);
        check_log_full("gap");
        check_dump("gap_dump", 31);

        // Reset mid-session after 10 words
        clear_model();
        pulse_start();
        load_words(10, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check_vec("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
        check_vec("midrst_busy", 64'(busy), 64'd0);
        check_vec("midrst_in_ready", 64'(in_ready), 64'd0);
        step();
        check_vec("midrst_rf_we", 64'(rf_we), 64'd0);
        check_dump("midrst_dump", 10);
        reset = 1'b1;
        step();
        clear_model();
        pulse_start();
        load_words(31, 1'b0);
        for (int c = 0; c < 4; c++) step();
        check_log_full("reload");

        // skip from IDLE
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_model();
        skip = 1'b1;
        step();
        skip = 1'b0;
        check_vec("skip_busy", 64'(busy), 64'd1);
        check_vec("skip_in_ready", 64'(in_ready), 64'd0);
        check_vec("skip_cpu_reset", 64'(cpu_reset), 64'd1);
        step();
        check_vec("skip_hold2_done", 64'(done), 64'd0);
        step();
        check_vec("skip_done", 64'(done), 64'd1);
        check_vec("skip_cpu_reset_rel", 64'(cpu_reset), 64'd0);
        step();
        check_vec("skip_done_drop", 64'(done), 64'd0);
        check_vec("skip_writes", 64'(log_reg.size()), 64'd0);

        // start and skip together: start wins
        reset = 1'b0;
        step();
        reset = 1'b1;
        start = 1'b1; skip = 1'b1;
        step();
        start = 1'b0; skip = 1'b0;
        check_vec("both_in_ready", 64'(in_ready), 64'd1);
        check_vec("both_busy", 64'(busy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_regfile_preloader
`default_nettype wire
